ws2812_decoder: RTL and testbench
=================================

# ws2812_decoder

Single-wire WS2812 stream receiver: samples the NRZ data line, classifies each high pulse as a 0 or 1 bit, and assembles 24-bit GRB pixel words. It builds a 64-cell occupancy grid (cell lit when its pixel word is non-zero) and publishes that grid when the line-low latch gap ends a frame. It sits at the far end of the LED driver's data pin, for hardware loopback checks and for benches that compare decoded frames against the Game of Life engine's grid.

## Interface
- `CLK_HZ`, 12_000_000, system clock frequency; documentation only, not used by logic.
- `BIT_THRESH`, 7, high-pulse width in cycles at or above which a bit decodes as 1.
- `MIN_HIGH`, 2, high pulses shorter than this are treated as glitches and ignored.
- `MAX_HIGH`, 20, high pulses longer than this are errors (strict mode only).
- `RESET_CYCLES`, 600, continuous low cycles that end a frame (50 us at 12 MHz).
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `din` in 1: raw WS2812 data line, asynchronous to `clk`.
- `pixel_valid` out 1: one-cycle strobe; a pixel word completed.
- `pixel_data` out 24: GRB word, first-received bit in bit 23.
- `pixel_index` out 6: index of `pixel_data` within the frame.
- `frame_valid` out 1: one-cycle strobe; `grid` updated.
- `grid` out 64: last completed frame; bit i = pixel i non-zero; row i/8, col i%8.
- `frame_err` out 1: sticky per frame; set on partial pixel, overflow (>64 pixels) or strict violation; cleared at the next `frame_valid` after being reported.

## Operation
- `din` passes through a 2-flop synchronizer; edges are detected on the synchronized value.
- States:
  - SYNC (after reset): wait for RESET_CYCLES of continuous low, then go to IDLE without asserting `frame_valid`. Any high restarts the count.
  - IDLE: a rising edge goes to HIGH.
  - HIGH: count width; on falling edge, width < MIN_HIGH is ignored, otherwise shift in bit (width >= BIT_THRESH); go to LOW.
  - LOW: count low cycles; a rising edge goes to HIGH; count reaching RESET_CYCLES ends the frame, then IDLE.
- On the 24th bit of a pixel:
  - pulse `pixel_valid` with data and index;
  - write the working-grid bit at that index;
  - increment the index and clear the bit counter.
- Pixels beyond index 63 are not written to the grid; set the error flag; index saturates at 63; `pixel_valid` is still pulsed with index 63.
- Frame end: copy the working grid to `grid`, pulse `frame_valid`, and drive `frame_err` from the accumulated flags. Then clear the working grid, index, bit counter and flags.
  - A non-zero bit count at frame end sets `frame_err` and discards the partial pixel.
  - A frame with zero pixels still pulses `frame_valid` and publishes an all-zero grid.
- Width and low counters saturate; they never wrap.
- Asserting `rst_n` mid-frame aborts the frame; `grid` returns to 0 and the state returns to SYNC.

## Timing
- Reset values: all outputs 0; state SYNC.
- Latency, `din` edge to internal edge detect: 2 cycles.
- `pixel_valid` is asserted 1 cycle after the detected falling edge of bit 24; `pixel_data` and `pixel_index` are valid only while `pixel_valid` is high.
- `frame_valid` is asserted the cycle the low count equals RESET_CYCLES, once per gap; `grid` changes in that same cycle and holds until the next `frame_valid`.
- If a rising edge and the low count reaching RESET_CYCLES fall in the same cycle, frame end wins; the edge then starts a new bit.

## Configuration
- `WS2812_DEC_STRICT_EN` defined:
  - high pulses longer than MAX_HIGH set `frame_err` and are discarded;
  - low gaps longer than MAX_HIGH but shorter than RESET_CYCLES inside a pixel set `frame_err`.
- Not defined: no upper width check; any pulse >= MIN_HIGH decodes; `frame_err` covers only partial-pixel and overflow.

## Structure
- Package `ws2812_pkg` holds:
  - `PIXEL_BITS`=24, `GRID_CELLS`=64;
  - the state enum `dec_state_t` (SYNC, IDLE, HIGH, LOW);
  - default timing constants.
- One sub-module, `ws2812_pulse_meas`: synchronizer, edge detect, and saturating high/low width counters. It outputs `fall_strobe` + `high_width`, plus `low_count`.

## Test plan
- Hold low 600 cycles, then send 64 pixels alternating 0x000000/0x0A0A0A, then 600 low → one `frame_valid`, `grid`=0xAAAA_AAAA_AAAA_AAAA, `frame_err`=0.
- Send pixel 0x800001 → `pixel_valid` with `pixel_data`=0x800001, `pixel_index`=0; 4-cycle highs decode 0, 9-cycle highs decode 1.
- Send 30 bits then a 600-cycle gap → `frame_valid`, `frame_err`=1, `grid` excludes the partial pixel.
- Send 66 pixels, all 0xFFFFFF → `grid`=all ones, `frame_err`=1, last two strobes report index 63.
- Inject 1-cycle high glitches between bits → decoded data unchanged; with strict mode, a 25-cycle high → `frame_err`=1.
- Deassert `rst_n` at pixel 10 → all outputs 0; no `frame_valid` until 600 low cycles plus a full frame.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared constants and decoder state type for the WS2812 stream receiver.
package ws2812_pkg;

    localparam int unsigned PIXEL_BITS = 24;
    localparam int unsigned GRID_CELLS = 64;
    localparam int unsigned HIGH_W     = 8;
    localparam int unsigned LOW_W      = 16;

    localparam int unsigned DEF_CLK_HZ       = 12_000_000;
    localparam int unsigned DEF_BIT_THRESH   = 7;
    localparam int unsigned DEF_MIN_HIGH     = 2;
    localparam int unsigned DEF_MAX_HIGH     = 20;
    localparam int unsigned DEF_RESET_CYCLES = 600;

    typedef enum logic [1:0] {
        StSync,
        StIdle,
        StHigh,
        StLow
    } dec_state_t;

endpackage

// File: rtl/ws2812_decoder_if.sv
// Decoder bus: raw data line in, pixel and frame results out.
interface ws2812_decoder_if;
    import ws2812_pkg::*;

    logic                    din;
    logic                    pixel_valid;
    logic [PIXEL_BITS-1:0]   pixel_data;
    logic [5:0]              pixel_index;
    logic                    frame_valid;
    logic [GRID_CELLS-1:0]   grid;
    logic                    frame_err;

    // master: the decoder itself; slave: whoever drives the line and consumes results
    modport master (
        input  din,
        output pixel_valid, pixel_data, pixel_index, frame_valid, grid, frame_err
    );
    modport slave (
        output din,
        input  pixel_valid, pixel_data, pixel_index, frame_valid, grid, frame_err
    );
endinterface

// File: rtl/ws2812_pulse_meas.sv
// Line synchronizer, edge detect and saturating high/low run-length counters.
module ws2812_pulse_meas
    import ws2812_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_din,
    output logic              o_rise,
    output logic              o_fall,
    output logic [HIGH_W-1:0] o_high_width,
    output logic [LOW_W-1:0]  o_low_count
);

    logic [1:0]        r_sync;
    logic              r_prev;
    logic [HIGH_W-1:0] r_high;
    logic [LOW_W-1:0]  r_low;
    logic              w_line;

    assign w_line = r_sync[1];
    assign o_rise = w_line & ~r_prev;
    assign o_fall = ~w_line & r_prev;
    assign o_high_width = r_high;
    assign o_low_count  = r_low;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_high <= '0;
            r_low  <= '0;
        end else begin
            r_sync <= {r_sync[0], i_din};
            r_prev <= w_line;
            // At a fall r_high holds the full width of the pulse just ended
            if (o_rise) begin
                r_high <= HIGH_W'(1);
            end else if (w_line && (r_high != '1)) begin
                r_high <= r_high + 1'b1;
            end
            if (o_fall) begin
                r_low <= LOW_W'(1);
            end else if (w_line) begin
                r_low <= '0;
            end else if (r_low != '1) begin
                r_low <= r_low + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ws2812_decoder.sv
// WS2812 receiver: decodes GRB pixels and publishes a 64-cell occupancy grid per frame.
// Define WS2812_DEC_STRICT_EN to flag over-long high pulses and in-pixel low gaps.
module ws2812_decoder
    import ws2812_pkg::*;
#(
    parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
    parameter int unsigned BIT_THRESH   = DEF_BIT_THRESH,
    parameter int unsigned MIN_HIGH     = DEF_MIN_HIGH,
    parameter int unsigned MAX_HIGH     = DEF_MAX_HIGH,
    parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES
) (
    input logic               clk,
    input logic               rst_n,
    ws2812_decoder_if.master  bus
);

    // CLK_HZ is informational; it only takes part in this sanity check
    if (CLK_HZ == 0 || BIT_THRESH < MIN_HIGH || MAX_HIGH >= RESET_CYCLES) begin : g_cfg_check
        $error("ws2812_decoder: inconsistent timing parameters");
    end

    localparam logic [HIGH_W-1:0] L_THRESH = HIGH_W'(BIT_THRESH);
    localparam logic [HIGH_W-1:0] L_MIN    = HIGH_W'(MIN_HIGH);
    localparam logic [LOW_W-1:0]  L_RESET  = LOW_W'(RESET_CYCLES);

    logic                  w_rise;
    logic                  w_fall;
    logic [HIGH_W-1:0]     w_high_width;
    logic [LOW_W-1:0]      w_low_count;
    logic                  w_bit;
    logic                  w_glitch;
    logic                  w_too_long;
    logic                  w_last;
    logic [PIXEL_BITS-1:0] w_word;

    dec_state_t            r_state;
    logic [PIXEL_BITS-2:0] r_shift;
    logic [4:0]            r_bit_cnt;
    logic [5:0]            r_index;
    logic                  r_full;
    logic                  r_err;
    logic [GRID_CELLS-1:0] r_work;
    logic                  r_pixel_valid;
    logic [PIXEL_BITS-1:0] r_pixel_data;
    logic [5:0]            r_pixel_index;
    logic                  r_frame_valid;
    logic [GRID_CELLS-1:0] r_grid;
    logic                  r_frame_err;

    ws2812_pulse_meas u_meas (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_din        (bus.din),
        .o_rise       (w_rise),
        .o_fall       (w_fall),
        .o_high_width (w_high_width),
        .o_low_count  (w_low_count)
    );

    assign w_bit    = (w_high_width >= L_THRESH);
    assign w_glitch = (w_high_width < L_MIN);
    assign w_last   = (r_bit_cnt == 5'(PIXEL_BITS - 1));
    assign w_word   = {r_shift, w_bit};

`ifdef WS2812_DEC_STRICT_EN
    localparam logic [HIGH_W-1:0] L_MAX     = HIGH_W'(MAX_HIGH);
    localparam logic [LOW_W-1:0]  L_GAP_MAX = LOW_W'(MAX_HIGH + 1);
    assign w_too_long = (w_high_width > L_MAX);
`else
    assign w_too_long = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StSync;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_index       <= '0;
            r_full        <= 1'b0;
            r_err         <= 1'b0;
            r_work        <= '0;
            r_pixel_valid <= 1'b0;
            r_pixel_data  <= '0;
            r_pixel_index <= '0;
            r_frame_valid <= 1'b0;
            r_grid        <= '0;
            r_frame_err   <= 1'b0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_frame_valid <= 1'b0;
            unique case (r_state)
                StSync: if (w_low_count == L_RESET) r_state <= StIdle;
                StIdle: if (w_rise) r_state <= StHigh;
                StHigh: begin
                    if (w_fall) begin
                        r_state <= StLow;
                        if (w_too_long) begin
                            r_err <= 1'b1;
                        end else if (!w_glitch) begin
                            if (w_last) begin
                                r_pixel_valid <= 1'b1;
                                r_pixel_data  <= w_word;
                                r_pixel_index <= r_index;
                                r_bit_cnt     <= '0;
                                // Index parks at the last cell once the grid is full
                                if (r_full) begin
                                    r_err <= 1'b1;
                                end else begin
                                    r_work[r_index] <= |w_word;
                                    if (r_index == 6'(GRID_CELLS - 1)) r_full <= 1'b1;
                                    else r_index <= r_index + 1'b1;
                                end
                            end else begin
                                r_shift   <= w_word[PIXEL_BITS-2:0];
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                StLow: begin
                    if (w_low_count == L_RESET) begin
                        r_grid        <= r_work;
                        r_frame_valid <= 1'b1;
                        r_frame_err   <= r_err | (r_bit_cnt != '0);
                        r_work        <= '0;
                        r_index       <= '0;
                        r_bit_cnt     <= '0;
                        r_full        <= 1'b0;
                        r_err         <= 1'b0;
                        r_state       <= w_rise ? StHigh : StIdle;
                    end else begin
                        if (w_rise) r_state <= StHigh;
`ifdef WS2812_DEC_STRICT_EN
                        if (w_low_count == L_GAP_MAX && r_bit_cnt != '0) r_err <= 1'b1;
`endif
                    end
                end
                default: r_state <= StSync;
            endcase
        end
    end

    assign bus.pixel_valid = r_pixel_valid;
    assign bus.pixel_data  = r_pixel_data;
    assign bus.pixel_index = r_pixel_index;
    assign bus.frame_valid = r_frame_valid;
    assign bus.grid        = r_grid;
    assign bus.frame_err   = r_frame_err;

endmodule

// File: tb/tb_ws2812_decoder.sv
// Scoreboard bench for ws2812_decoder: directed pixel/frame stimulus, decoupled monitor.
module tb_ws2812_decoder;
    import ws2812_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ws2812_decoder_if bus ();

    ws2812_decoder #(
        .CLK_HZ       (DEF_CLK_HZ),
        .BIT_THRESH   (DEF_BIT_THRESH),
        .MIN_HIGH     (DEF_MIN_HIGH),
        .MAX_HIGH     (DEF_MAX_HIGH),
        .RESET_CYCLES (DEF_RESET_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int frames_seen = 0;
    int frames_exp = 0;
    int m_cnt = 0;
    logic [29:0] pix_q[$];
    logic [64:0] frm_q[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    task automatic drive(input logic v, input int n);
        bus.din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        drive(1'b1, b ? 9 : 4);
        drive(1'b0, 4);
    endtask

    task automatic send_pixel(input logic [23:0] w, input bit exp_it, input bit glitch);
        if (exp_it) begin
            pix_q.push_back({w, 6'((m_cnt > 63) ? 63 : m_cnt)});
            m_cnt++;
        end
        for (int i = 23; i >= 0; i--) begin
            send_bit(w[i]);
            if (glitch) begin
                drive(1'b1, 1);
                drive(1'b0, 3);
            end
        end
    endtask

    task automatic gap(input logic [63:0] grid, input logic err);
        frm_q.push_back({err, grid});
        frames_exp++;
        m_cnt = 0;
        drive(1'b0, 620);
    endtask

    // Monitor: pops expectations whenever the DUT strobes a result
    initial begin
        logic [29:0] pe;
        logic [64:0] fe;
        forever begin
            @(negedge clk);
            if (bus.pixel_valid) begin
                if (pix_q.size() == 0) begin
                    checks++;
                    $display("FAIL pix_unexpected: data %h index %0d, none expected",
                             bus.pixel_data, bus.pixel_index);
                end else begin
                    pe = pix_q.pop_front();
                    chk("pix_data", 64'(bus.pixel_data), 64'(pe[29:6]));
                    chk("pix_index", 64'(bus.pixel_index), 64'(pe[5:0]));
                end
            end
            if (bus.frame_valid) begin
                frames_seen++;
                if (frm_q.size() == 0) begin
                    checks++;
                    $display("FAIL frame_unexpected: grid %h err %b, none expected",
                             bus.grid, bus.frame_err);
                end else begin
                    fe = frm_q.pop_front();
                    chk("frame_grid", bus.grid, fe[63:0]);
                    chk("frame_err", 64'(bus.frame_err), 64'(fe[64]));
                end
            end
        end
    end

    initial begin
        bus.din = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pixel_valid", 64'(bus.pixel_valid), 64'd0);
        chk("rst_frame_valid", 64'(bus.frame_valid), 64'd0);
        chk("rst_grid", bus.grid, 64'd0);
        chk("rst_frame_err", 64'(bus.frame_err), 64'd0);
        rst_n = 1'b1;
        drive(1'b0, 620);

        // Single pixel: bit 23 and bit 0 set
        send_pixel(24'h800001, 1, 0);
        gap(64'h1, 1'b0);

        // 64 pixels alternating zero / non-zero
        for (int i = 0; i < 64; i++) send_pixel((i % 2) ? 24'h0A0A0A : 24'h000000, 1, 0);
        gap(64'hAAAA_AAAA_AAAA_AAAA, 1'b0);

        // 30 bits: one full pixel plus a 6-bit partial
        send_pixel(24'h123456, 1, 0);
        for (int i = 0; i < 6; i++) send_bit(i[0]);
        gap(64'h1, 1'b1);

        // Overflow: 66 pixels, the last three strobes report index 63
        for (int i = 0; i < 66; i++) send_pixel(24'hFFFFFF, 1, 0);
        gap({64{1'b1}}, 1'b1);

        // 1-cycle glitches between bits are ignored
        send_pixel(24'hA5A5A5, 1, 1);
        send_pixel(24'h00F00F, 1, 1);
        gap(64'h3, 1'b0);

`ifdef WS2812_DEC_STRICT_EN
        drive(1'b1, 25);
        drive(1'b0, 4);
        send_pixel(24'h3C3C3C, 1, 0);
        gap(64'h1, 1'b1);
`endif

        // Reset mid-frame at pixel 10
        for (int i = 0; i < 10; i++) send_pixel(24'h0000FF, 1, 0);
        drive(1'b0, 6);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_pixel_valid", 64'(bus.pixel_valid), 64'd0);
        chk("midrst_frame_valid", 64'(bus.frame_valid), 64'd0);
        chk("midrst_grid", bus.grid, 64'd0);
        chk("midrst_frame_err", 64'(bus.frame_err), 64'd0);
        chk("midrst_pix_pending", 64'(pix_q.size()), 64'd0);
        m_cnt = 0;
        rst_n = 1'b1;
        // Still syncing: these pixels and the following gap must produce nothing
        for (int i = 0; i < 3; i++) send_pixel(24'hFFFFFF, 0, 0);
        drive(1'b0, 620);
        send_pixel(24'h000001, 1, 0);
        send_pixel(24'h100000, 1, 0);
        gap(64'h3, 1'b0);

        drive(1'b0, 10);
        chk("pix_q_empty", 64'(pix_q.size()), 64'd0);
        chk("frm_q_empty", 64'(frm_q.size()), 64'd0);
        chk("frame_count", 64'(frames_seen), 64'(frames_exp));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
